mdsa_sort_ctrl: RTL and testbench

//  Sequencer for the N x N multidimensional bitonic sorter (MDSA_sorter).

---
 rtl/mdsa_sort_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mdsa_sort_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdsa_sort_ctrl.sv
// Sequencer for the N x N multidimensional bitonic sorter.
// Runs PHASES shear-sort passes, then holds the result until consumed.
module mdsa_sort_ctrl #(
   parameter int N      = 8,
   parameter int LAT    = 6,
   parameter int PHASES = 7,
   parameter int PW     = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          asc,
   input  logic          abort,
   input  logic          out_ready,
   output logic          out_valid,
   output logic          en,
   output logic          start,
   output logic          trans,
   output logic [N-1:0]  dir,
   output logic [PW-1:0] phase,
   output logic          busy
);

   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_EDGE,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [PW-1:0] phase_d;
   logic [N-1:0]  dir_d;
   logic          asc_q, asc_d;
   logic          en_d, start_d, trans_d;
   logic          ov_d, busy_d;

   // Even non-final passes sort rows in snake order; the rest follow asc.
   function automatic logic [N-1:0] dir_for(
      input logic [PW-1:0] ph,
      input logic          a
   );
      logic [N-1:0] d;
      d = '0;
      for (int i = 0; i < N; i++) begin
         if (!ph[0] && ph != LAST)
            d[i] = a ^ i[0];
         else
            d[i] = a;
      end
      return d;
   endfunction

   assign req_ready = (state == S_IDLE);

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      phase_d = phase;
      dir_d   = dir;
      asc_d   = asc_q;
      en_d    = en;
      start_d = start;
      trans_d = 1'b0;
      ov_d    = out_valid;
      busy_d  = busy;
      unique case (state)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_LOAD;
               asc_d   = asc;
               phase_d = '0;
               dir_d   = dir_for('0, asc);
               en_d    = 1'b1;
               start_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_LOAD: begin
            state_d = S_EDGE;
            en_d    = 1'b1;
            trans_d = 1'b1;
            start_d = (phase == '0);
         end
         S_EDGE: begin
            state_d = S_WAIT;
            cnt_d   = CW'(LAT - 1);
            en_d    = 1'b1;
            start_d = 1'b0;
         end
         S_WAIT: begin
            if (cnt != '0) begin
               cnt_d = cnt - CW'(1);
            end else if (phase == LAST) begin
               state_d = S_HOLD;
               en_d    = 1'b0;
               start_d = 1'b0;
               ov_d    = 1'b1;
            end else begin
               state_d = S_EDGE;
               phase_d = phase + PW'(1);
               dir_d   = dir_for(phase + PW'(1), asc_q);
               trans_d = 1'b1;
               start_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               state_d = S_IDLE;
               ov_d    = 1'b0;
               busy_d  = 1'b0;
               phase_d = '0;
               dir_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Abort beats any pending handshake and clears like reset
      if (abort && state != S_IDLE) begin
         state_d = S_IDLE;
         phase_d = '0;
         dir_d   = '0;
         en_d    = 1'b0;
         start_d = 1'b0;
         trans_d = 1'b0;
         ov_d    = 1'b0;
         busy_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         phase     <= '0;
         dir       <= '0;
         asc_q     <= 1'b0;
         en        <= 1'b0;
         start     <= 1'b0;
         trans     <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         phase     <= phase_d;
         dir       <= dir_d;
         asc_q     <= asc_d;
         en        <= en_d;
         start     <= start_d;
         trans     <= trans_d;
         out_valid <= ov_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_mdsa_sort_ctrl.sv
// Bench for mdsa_sort_ctrl: vector table, directed sequences and
// randomized sorts against a timing/shear-sort reference model.
module tb_mdsa_sort_ctrl;

   localparam int PH = 7;

   typedef struct packed {
      logic       rdy;
      logic       ov;
      logic       bz;
      logic       en;
      logic       st;
      logic       tr;
      logic [2:0] ph;
      logic [7:0] dir;
   } obs_t;

   typedef struct {
      bit   rst;
      bit   rv;
      bit   asc;
      bit   ab;
      bit   ordy;
      obs_t exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] rv, as_in, ab, ordy;

   logic       rdy0, ov0, bz0, en0, st0, tr0;
   logic [2:0] ph0;
   logic [7:0] dir0;
   logic       rdy1, ov1, bz1, en1, st1, tr1;
   logic [2:0] ph1;
   logic [7:0] dir1;

   obs_t o0, o1;
   assign o0 = {rdy0, ov0, bz0, en0, st0, tr0, ph0, dir0};
   assign o1 = {rdy1, ov1, bz1, en1, st1, tr1, ph1, dir1};

   int   checks = 0;
   int   errs   = 0;
   int   m[8][8];
   vec_t vecs[11];

   always #5 clk = ~clk;

   mdsa_sort_ctrl u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(rv[0]), .req_ready(rdy0),
      .asc(as_in[0]), .abort(ab[0]),
      .out_ready(ordy[0]), .out_valid(ov0),
      .en(en0), .start(st0), .trans(tr0),
      .dir(dir0), .phase(ph0), .busy(bz0)
   );

   mdsa_sort_ctrl #(.LAT(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(rv[1]), .req_ready(rdy1),
      .asc(as_in[1]), .abort(ab[1]),
      .out_ready(ordy[1]), .out_valid(ov1),
      .en(en1), .start(st1), .trans(tr1),
      .dir(dir1), .phase(ph1), .busy(bz1)
   );

   function automatic obs_t mko(bit rdy, bit ov, bit bz, bit en,
                                bit st, bit tr, int ph,
                                logic [7:0] d);
      obs_t o;
      o.rdy = rdy; o.ov = ov; o.bz = bz; o.en = en;
      o.st  = st;  o.tr = tr; o.ph = 3'(ph); o.dir = d;
      return o;
   endfunction

   // Direction of each row/column for pass k
   function automatic logic [7:0] dirf(int k, bit a);
      logic [7:0] d;
      for (int i = 0; i < 8; i++) begin
         if (k % 2 == 0 && k != PH - 1 && i % 2 == 1)
            d[i] = !a;
         else
            d[i] = a;
      end
      return d;
   endfunction

   // Expected outputs t cycles after the accepting edge
   function automatic obs_t model(int t, bit a, int lat);
      int per, hold_t, k, off;
      per    = lat + 1;
      hold_t = 2 + per * PH;
      if (t == 1)
         return mko(0, 0, 1, 1, 1, 0, 0, dirf(0, a));
      if (t >= hold_t)
         return mko(0, 1, 1, 0, 0, 0, PH - 1, dirf(PH - 1, a));
      k   = (t - 2) / per;
      off = (t - 2) % per;
      return mko(0, 0, 1, 1, (k == 0 && off == 0), (off == 0),
                 k, dirf(k, a));
   endfunction

   function automatic obs_t cur(int sel);
      return (sel != 0) ? o1 : o0;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One sorter pass on the bench-side matrix, as the array would do it
   task automatic apply_pass(logic [2:0] ph, logic [7:0] d);
      int q[$];
      for (int i = 0; i < 8; i++) begin
         q.delete();
         for (int j = 0; j < 8; j++)
            q.push_back(ph[0] ? m[j][i] : m[i][j]);
         if (d[i]) q.sort();
         else q.rsort();
         for (int j = 0; j < 8; j++) begin
            if (ph[0]) m[j][i] = q[j];
            else m[i][j] = q[j];
         end
      end
   endtask

   task automatic run_sort(int sel, bit a, int bp, int abort_t,
                           bit keep_rv);
      int   lat, hold_t, pulses, bad;
      int   q[$];
      obs_t o;
      lat    = (sel != 0) ? 1 : 6;
      hold_t = 2 + (lat + 1) * PH;
      pulses = 0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            m[r][c] = $urandom_range(0, 255);
      as_in[sel] = a;
      rv[sel]    = 1'b1;
      for (int t = 1; t <= hold_t + bp; t++) begin
         step();
         if (!keep_rv) rv[sel] = 1'b0;
         o = cur(sel);
         chk($sformatf("seq%0d t=%0d", sel, t), 32'(o),
             32'(model(t, a, lat)));
         if (o.tr) begin
            apply_pass(o.ph, o.dir);
            pulses++;
         end
         if (t == abort_t) begin
            ab[sel] = 1'b1;
            step();
            ab[sel] = 1'b0;
            rv[sel] = 1'b0;
            chk($sformatf("abort%0d t=%0d", sel, t), 32'(cur(sel)),
                32'(mko(1, 0, 0, 0, 0, 0, 0, 8'h00)));
            return;
         end
      end
      ordy[sel] = 1'b1;
      step();
      ordy[sel] = 1'b0;
      o = cur(sel);
      o.dir = '0;
      chk($sformatf("handshake%0d", sel), 32'(o),
          32'(mko(1, 0, 0, 0, 0, 0, 0, 8'h00)));
      chk($sformatf("pulses%0d", sel), pulses, PH);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            q.push_back(m[r][c]);
      if (a) q.sort();
      else q.rsort();
      bad = 0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            if (m[r][c] != q[r * 8 + c]) bad++;
      chk($sformatf("matrix%0d asc=%0d", sel, a), bad, 0);
      if (keep_rv) begin
         step();
         chk($sformatf("reaccept%0d", sel), 32'(cur(sel)),
             32'(model(1, a, lat)));
         ab[sel] = 1'b1;
         rv[sel] = 1'b0;
         step();
         ab[sel] = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      obs_t idle;
      int   sel, hold_t, abt;
      bit   a;
      idle  = mko(1, 0, 0, 0, 0, 0, 0, 8'h00);
      rst   = 1'b0;
      rv    = '0;
      as_in = '0;
      ab    = '0;
      ordy  = '0;

      vecs[0]  = '{0, 1, 1, 0, 0, idle};
      vecs[1]  = '{1, 0, 0, 1, 0, idle};
      vecs[2]  = '{1, 0, 0, 0, 1, idle};
      vecs[3]  = '{1, 1, 1, 1, 0, mko(0, 0, 1, 1, 1, 0, 0, 8'h55)};
      vecs[4]  = '{1, 0, 1, 0, 0, mko(0, 0, 1, 1, 1, 1, 0, 8'h55)};
      vecs[5]  = '{1, 0, 1, 1, 1, idle};
      vecs[6]  = '{1, 1, 0, 0, 0, mko(0, 0, 1, 1, 1, 0, 0, 8'hAA)};
      vecs[7]  = '{1, 0, 0, 0, 0, mko(0, 0, 1, 1, 1, 1, 0, 8'hAA)};
      vecs[8]  = '{1, 0, 0, 0, 0, mko(0, 0, 1, 1, 0, 0, 0, 8'hAA)};
      vecs[9]  = '{0, 0, 0, 0, 0, idle};
      vecs[10] = '{1, 0, 0, 0, 0, idle};

      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         rst      = vecs[i].rst;
         rv[0]    = vecs[i].rv;
         as_in[0] = vecs[i].asc;
         ab[0]    = vecs[i].ab;
         ordy[0]  = vecs[i].ordy;
         step();
         chk($sformatf("vec%0d", i), 32'(o0), 32'(vecs[i].exp));
      end
      rv[0]   = 1'b0;
      ab[0]   = 1'b0;
      ordy[0] = 1'b0;

      // Reset held two cycles in the middle of a WAIT
      as_in[0] = 1'b1;
      rv[0]    = 1'b1;
      for (int t = 1; t <= 5; t++) begin
         step();
         rv[0] = 1'b0;
         chk($sformatf("pre-rst t=%0d", t), 32'(o0),
             32'(model(t, 1'b1, 6)));
      end
      rst = 1'b0;
      step();
      chk("rst cyc1", 32'(o0), 32'(idle));
      step();
      chk("rst cyc2", 32'(o0), 32'(idle));
      rst = 1'b1;
      step();
      chk("rst release", 32'(o0), 32'(idle));

      run_sort(0, 1'b1, 20, 0, 1'b0);
      run_sort(0, 1'b0, 0, 0, 1'b0);
      run_sort(0, 1'b1, 3, 16, 1'b0);
      run_sort(0, 1'b1, 0, 0, 1'b0);
      run_sort(0, 1'b0, 2, 0, 1'b1);
      run_sort(1, 1'b1, 0, 0, 1'b1);
      run_sort(1, 1'b0, 4, 0, 1'b0);

      for (int n = 0; n < 12; n++) begin
         sel    = $urandom_range(0, 1);
         a      = 1'($urandom);
         hold_t = 2 + ((sel != 0) ? 2 : 7) * PH;
         abt    = 0;
         if ($urandom_range(0, 3) == 0)
            abt = $urandom_range(1, hold_t);
         run_sort(sel, a, $urandom_range(0, 4), abt,
                  1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
